// File: rtl/sid_pkg.sv
// Shared types and constants for the SID-style multi-voice ADSR envelope block.
// Holds the envelope state enum, the attack period table and the exponential thresholds.
package sid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

    typedef enum logic {
        SCAN_IDLE = 1'b0,
        SCAN_RUN  = 1'b1
    } scan_state_e;

    localparam int CNT_W = 14;
    localparam int EXP_W = 5;

    localparam logic [7:0] EXP_TH_1  = 8'd93;
    localparam logic [7:0] EXP_TH_2  = 8'd54;
    localparam logic [7:0] EXP_TH_4  = 8'd26;
    localparam logic [7:0] EXP_TH_8  = 8'd14;
    localparam logic [7:0] EXP_TH_16 = 8'd6;

    function automatic logic [CNT_W-1:0] atk_period(input logic [3:0] idx);
        logic [CNT_W-1:0] p;
        case (idx)
            4'd0:    p = 14'd1;
            4'd1:    p = 14'd4;
            4'd2:    p = 14'd8;
            4'd3:    p = 14'd12;
            4'd4:    p = 14'd19;
            4'd5:    p = 14'd28;
            4'd6:    p = 14'd34;
            4'd7:    p = 14'd40;
            4'd8:    p = 14'd50;
            4'd9:    p = 14'd125;
            4'd10:   p = 14'd250;
            4'd11:   p = 14'd400;
            4'd12:   p = 14'd500;
            4'd13:   p = 14'd1500;
            4'd14:   p = 14'd2500;
            default: p = 14'd4000;
        endcase
        return p;
    endfunction

    // Slow-down factor for decay/release, taken from the level scaled to 8 bits.
    function automatic logic [EXP_W-1:0] exp_mult(input logic [7:0] lvl8);
        logic [EXP_W-1:0] m;
        if (lvl8 >= EXP_TH_1)       m = 5'd1;
        else if (lvl8 >= EXP_TH_2)  m = 5'd2;
        else if (lvl8 >= EXP_TH_4)  m = 5'd4;
        else if (lvl8 >= EXP_TH_8)  m = 5'd8;
        else if (lvl8 >= EXP_TH_16) m = 5'd16;
        else                        m = 5'd30;
        return m;
    endfunction

endpackage

// File: rtl/sid_env_step.sv
// Shared combinational envelope step: next state, level and counters for the
// voice currently under the scan pointer.
module sid_env_step
    import sid_pkg::*;
#(
    parameter int ENV_W  = 8,
    parameter int EXP_EN = 1
) (
    input  env_state_e       state_i,
    input  logic [ENV_W-1:0] level_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [EXP_W-1:0] ecnt_i,
    input  logic [3:0]       atk_i,
    input  logic [3:0]       dec_i,
    input  logic [3:0]       sus_i,
    input  logic [3:0]       rel_i,
    input  logic             gate_i,
    input  logic             gate_prev_i,
    output env_state_e       state_o,
    output logic [ENV_W-1:0] level_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic [EXP_W-1:0] ecnt_o
);

    localparam logic [ENV_W-1:0] LVL_MAX = '1;

    logic [11:0]      sus_rep;
    logic [ENV_W-1:0] sus_tgt;
    logic [7:0]       lvl8;
    env_state_e       st;
    logic [CNT_W-1:0] cnt;
    logic [EXP_W-1:0] ecnt;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] p_dr;
    logic [EXP_W-1:0] mult;
    logic [CNT_W:0]   cnt_inc;
    logic [EXP_W:0]   ecnt_inc;
    logic             cnt_hit;
    logic             ecnt_hit;
    logic             stepping;
    logic [CNT_W-1:0] adv_cnt;
    logic [EXP_W-1:0] adv_ecnt;

    assign sus_rep = {sus_i, sus_i, sus_i};
    assign sus_tgt = sus_rep[11 -: ENV_W];
    assign lvl8    = level_i[ENV_W-1 -: 8];

    // A gate edge retargets the voice and restarts its counters before this service counts.
    always_comb begin
        st   = state_i;
        cnt  = cnt_i;
        ecnt = ecnt_i;
        if (gate_i && !gate_prev_i) begin
            st   = ST_ATTACK;
            cnt  = '0;
            ecnt = '0;
        end else if (!gate_i && gate_prev_i) begin
            st   = ST_RELEASE;
            cnt  = '0;
            ecnt = '0;
        end
    end

    always_comb begin
        base = atk_period(atk_i);
        p_dr = atk_period((st == ST_DECAY) ? dec_i : rel_i);
        mult = 5'd1;
        if (st == ST_DECAY || st == ST_RELEASE) begin
            base = (p_dr << 1) + p_dr;
            if (EXP_EN != 0) begin
                mult = exp_mult(lvl8);
            end
        end
    end

    // The base period counts in cnt; ecnt counts completed base periods up to the multiplier.
    always_comb begin
        cnt_inc  = {1'b0, cnt} + 15'd1;
        ecnt_inc = {1'b0, ecnt} + 6'd1;
        cnt_hit  = (cnt_inc >= {1'b0, base});
        ecnt_hit = (ecnt_inc >= {1'b0, mult});
        stepping = cnt_hit && ecnt_hit;
        adv_cnt  = cnt_hit ? '0 : cnt_inc[CNT_W-1:0];
        adv_ecnt = ecnt;
        if (cnt_hit) begin
            adv_ecnt = ecnt_hit ? '0 : ecnt_inc[EXP_W-1:0];
        end
    end

    always_comb begin
        state_o = st;
        level_o = level_i;
        cnt_o   = cnt;
        ecnt_o  = ecnt;
        case (st)
            ST_ATTACK: begin
                cnt_o  = adv_cnt;
                ecnt_o = adv_ecnt;
                if (stepping) begin
                    if (level_i != LVL_MAX) begin
                        level_o = level_i + 1'b1;
                    end
                    if (level_i >= LVL_MAX - 1'b1) begin
                        state_o = ST_DECAY;
                    end
                end
            end
            ST_DECAY: begin
                if (level_i <= sus_tgt) begin
                    state_o = ST_SUSTAIN;
                    cnt_o   = '0;
                    ecnt_o  = '0;
                end else begin
                    cnt_o  = adv_cnt;
                    ecnt_o = adv_ecnt;
                    if (stepping) begin
                        level_o = level_i - 1'b1;
                        if (level_i - 1'b1 <= sus_tgt) begin
                            state_o = ST_SUSTAIN;
                        end
                    end
                end
            end
            ST_SUSTAIN: begin
                cnt_o  = '0;
                ecnt_o = '0;
                if (sus_tgt < level_i) begin
                    state_o = ST_DECAY;
                end
            end
            ST_RELEASE: begin
                if (level_i == '0) begin
                    state_o = ST_IDLE;
                    cnt_o   = '0;
                    ecnt_o  = '0;
                end else begin
                    cnt_o  = adv_cnt;
                    ecnt_o = adv_ecnt;
                    if (stepping) begin
                        level_o = level_i - 1'b1;
                        if (level_i == {{(ENV_W-1){1'b0}}, 1'b1}) begin
                            state_o = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_o = ST_IDLE;
                cnt_o   = '0;
                ecnt_o  = '0;
            end
        endcase
    end

endmodule

// File: rtl/sid_adsr_mux.sv
// Multi-voice ADSR envelope generator: a tick launches a scan that services one
// voice per clock through a single shared step datapath.
module sid_adsr_mux
    import sid_pkg::*;
#(
    parameter  int NUM_VOICES = 4,
    parameter  int ENV_W      = 8,
    parameter  int EXP_EN     = 1,
    localparam int VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_i,
    input  logic             wr_en_i,
    input  logic [VW-1:0]    wr_voice_i,
    input  logic [1:0]       wr_addr_i,
    input  logic [7:0]       wr_data_i,
    output logic             env_valid_o,
    output logic [VW-1:0]    env_voice_o,
    output logic [ENV_W-1:0] env_level_o,
    output logic             tick_overrun_o
);

    typedef struct packed {
        env_state_e       state;
        logic [ENV_W-1:0] level;
        logic [CNT_W-1:0] cnt;
        logic [EXP_W-1:0] ecnt;
        logic [3:0]       atk;
        logic [3:0]       dec;
        logic [3:0]       sus;
        logic [3:0]       rel;
        logic             gate;
        logic             gate_prev;
    } voice_t;

    scan_state_e      scan_q, scan_d;
    logic [VW-1:0]    ptr_q, ptr_d;
    logic             ovr_q, ovr_d;
    voice_t           voice_arr [NUM_VOICES];
    voice_t           cur;
    env_state_e       step_state;
    logic [ENV_W-1:0] step_level;
    logic [CNT_W-1:0] step_cnt;
    logic [EXP_W-1:0] step_ecnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= SCAN_IDLE;
            ptr_q  <= '0;
            ovr_q  <= 1'b0;
        end else begin
            scan_q <= scan_d;
            ptr_q  <= ptr_d;
            ovr_q  <= ovr_d;
        end
    end

    always_comb begin
        scan_d = scan_q;
        ptr_d  = ptr_q;
        ovr_d  = 1'b0;
        case (scan_q)
            SCAN_RUN: begin
                ovr_d = tick_i;
                if (ptr_q == VW'(NUM_VOICES - 1)) begin
                    scan_d = SCAN_IDLE;
                    ptr_d  = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                if (tick_i) begin
                    scan_d = SCAN_RUN;
                    ptr_d  = '0;
                end
            end
        endcase
    end

    assign cur = voice_arr[ptr_q];

    sid_env_step #(
        .ENV_W  (ENV_W),
        .EXP_EN (EXP_EN)
    ) u_step (
        .state_i     (cur.state),
        .level_i     (cur.level),
        .cnt_i       (cur.cnt),
        .ecnt_i      (cur.ecnt),
        .atk_i       (cur.atk),
        .dec_i       (cur.dec),
        .sus_i       (cur.sus),
        .rel_i       (cur.rel),
        .gate_i      (cur.gate),
        .gate_prev_i (cur.gate_prev),
        .state_o     (step_state),
        .level_o     (step_level),
        .cnt_o       (step_cnt),
        .ecnt_o      (step_ecnt)
    );

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        voice_t v_q;
        logic   svc;
        logic   wr_hit;

        assign svc    = (scan_q == SCAN_RUN) && (ptr_q == VW'(gi));
        assign wr_hit = wr_en_i && (wr_voice_i == VW'(gi));

        // A write landing on this voice's own slot is seen from its next service onward.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= '0;
            end else begin
                if (svc) begin
                    v_q.state     <= step_state;
                    v_q.level     <= step_level;
                    v_q.cnt       <= step_cnt;
                    v_q.ecnt      <= step_ecnt;
                    v_q.gate_prev <= v_q.gate;
                end
                if (wr_hit) begin
                    case (wr_addr_i)
                        2'd0:    {v_q.atk, v_q.dec} <= wr_data_i;
                        2'd1:    {v_q.sus, v_q.rel} <= wr_data_i;
                        2'd2:    v_q.gate <= wr_data_i[0];
                        default: ;
                    endcase
                end
            end
        end

        assign voice_arr[gi] = v_q;
    end

    assign env_valid_o    = (scan_q == SCAN_RUN);
    assign env_voice_o    = (scan_q == SCAN_RUN) ? ptr_q : '0;
    assign env_level_o    = (scan_q == SCAN_RUN) ? step_level : '0;
    assign tick_overrun_o = ovr_q;

endmodule
